// File: rtl/taxi_axi_pkg.sv
// Shared AXI4 definitions for the taxi interconnect: response codes and limits
// used by the default/terminating slave.
package taxi_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Widest rdata constant the error slave can carry; narrower buses truncate it.
    localparam int RDATA_MAX_W = 1024;

    typedef logic [1:0] axi_resp_t;

    function automatic logic is_err_resp(input axi_resp_t resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/taxi_axi_if.sv
// AXI4 bundle between the interconnect and one downstream slave, with separate
// write/read slave and master modports so each direction can be bound on its own.
interface taxi_axi_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
) ();

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic [USER_W-1:0]   buser;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [USER_W-1:0]   ruser;
    logic                rvalid;
    logic                rready;

    modport wr_slv (
        input  awid, awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready
    );

    modport rd_slv (
        input  arid, araddr, arlen, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );

    modport wr_mst (
        output awid, awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready
    );

    modport rd_mst (
        output arid, araddr, arlen, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

endinterface

// File: rtl/taxi_axi_err_slv_rd.sv
// Read half of the error slave: accepts one AR and returns arlen+1 constant beats
// with RLAST on the final one, echoing the captured ID and a fixed response.
//
// state  | meaning
// R_IDLE | arready high, waiting for an AR handshake
// R_DATA | rvalid high, streaming beats until the RLAST beat is taken
module taxi_axi_err_slv_rd
    import taxi_axi_pkg::*;
#(
    parameter logic [1:0]             RESP      = RESP_DECERR,
    parameter logic [RDATA_MAX_W-1:0] RDATA_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    taxi_axi_if.rd_slv     s_axi_rd
);

    localparam int ID_W   = $bits(s_axi_rd.arid);
    localparam int DATA_W = $bits(s_axi_rd.rdata);
    localparam int USER_W = $bits(s_axi_rd.ruser);

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    rd_state_t       r_state;
    rd_state_t       w_state_nxt;

    logic            r_arready;
    logic            r_rvalid;
    logic            r_rlast;
    logic [ID_W-1:0] r_rid;
    logic [7:0]      r_cnt;

    logic            w_ar_hs;
    logic            w_r_hs;

    assign w_ar_hs = s_axi_rd.arvalid && r_arready;
    assign w_r_hs  = r_rvalid && s_axi_rd.rready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (w_ar_hs)           w_state_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_state_nxt = R_IDLE;
            default:                        w_state_nxt = R_IDLE;
        endcase
    end

    // r_cnt holds the beats still to come after the one on the bus; rlast flags
    // the beat where it reaches zero, so the counter is never decremented past 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_cnt     <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= (w_state_nxt == R_IDLE);
            r_rvalid  <= (w_state_nxt == R_DATA);
            if (w_ar_hs) begin
                r_rid   <= s_axi_rd.arid;
                r_cnt   <= s_axi_rd.arlen;
                r_rlast <= (s_axi_rd.arlen == 8'd0);
            end else if (w_r_hs) begin
                if (r_rlast) begin
                    r_rlast <= 1'b0;
                end else begin
                    r_cnt   <= r_cnt - 8'd1;
                    r_rlast <= (r_cnt == 8'd1);
                end
            end
        end
    end

    assign s_axi_rd.arready = r_arready;
    assign s_axi_rd.rvalid  = r_rvalid;
    assign s_axi_rd.rlast   = r_rlast;
    assign s_axi_rd.rid     = r_rid;
    assign s_axi_rd.rresp   = RESP;
    assign s_axi_rd.rdata   = DATA_W'(RDATA_VAL);
    assign s_axi_rd.ruser   = {USER_W{1'b0}};

endmodule

// File: rtl/taxi_axi_err_slv_wr.sv
// Write half of the error slave: accepts one AW, drains W until WLAST (awlen is
// ignored), then returns a single B carrying the captured ID and a fixed response.
//
// state  | meaning
// W_IDLE | awready high, waiting for an AW handshake
// W_DATA | wready high, swallowing beats until WLAST
// W_RESP | bvalid high with captured bid, waiting for bready
module taxi_axi_err_slv_wr
    import taxi_axi_pkg::*;
#(
    parameter logic [1:0] RESP = RESP_DECERR
) (
    input  logic           clk,
    input  logic           rst_n,
    taxi_axi_if.wr_slv     s_axi_wr
);

    localparam int ID_W   = $bits(s_axi_wr.awid);
    localparam int USER_W = $bits(s_axi_wr.buser);

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    wr_state_t       r_state;
    wr_state_t       w_state_nxt;

    logic            r_awready;
    logic            r_wready;
    logic            r_bvalid;
    logic [ID_W-1:0] r_bid;

    logic            w_aw_hs;
    logic            w_wlast_hs;
    logic            w_b_hs;

    // Handshakes use the registered readies, so a handshake implies the matching state.
    assign w_aw_hs    = s_axi_wr.awvalid && r_awready;
    assign w_wlast_hs = s_axi_wr.wvalid && r_wready && s_axi_wr.wlast;
    assign w_b_hs     = r_bvalid && s_axi_wr.bready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            W_IDLE:  if (w_aw_hs)    w_state_nxt = W_DATA;
            W_DATA:  if (w_wlast_hs) w_state_nxt = W_RESP;
            W_RESP:  if (w_b_hs)     w_state_nxt = W_IDLE;
            default:                 w_state_nxt = W_IDLE;
        endcase
    end

    // Readies and bvalid are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_awready <= (w_state_nxt == W_IDLE);
            r_wready  <= (w_state_nxt == W_DATA);
            r_bvalid  <= (w_state_nxt == W_RESP);
            if (w_aw_hs) begin
                r_bid <= s_axi_wr.awid;
            end
        end
    end

    assign s_axi_wr.awready = r_awready;
    assign s_axi_wr.wready  = r_wready;
    assign s_axi_wr.bvalid  = r_bvalid;
    assign s_axi_wr.bid     = r_bid;
    assign s_axi_wr.bresp   = RESP;
    assign s_axi_wr.buser   = {USER_W{1'b0}};

endmodule

// File: rtl/taxi_axi_err_slv.sv
// AXI4 default slave for unmapped interconnect ports: terminates every burst with
// a fixed error response; read and write halves run independently.
module taxi_axi_err_slv
    import taxi_axi_pkg::*;
#(
    parameter logic [1:0]             RESP      = RESP_DECERR,
    parameter logic [RDATA_MAX_W-1:0] RDATA_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    taxi_axi_if.wr_slv     s_axi_wr,
    taxi_axi_if.rd_slv     s_axi_rd
);

    taxi_axi_err_slv_wr #(
        .RESP      (RESP)
    ) u_wr (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_axi_wr  (s_axi_wr)
    );

    taxi_axi_err_slv_rd #(
        .RESP      (RESP),
        .RDATA_VAL (RDATA_VAL)
    ) u_rd (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_axi_rd  (s_axi_rd)
    );

endmodule

// File: tb/tb_taxi_axi_err_slv.sv
// Directed + randomized bench for the AXI4 error slave; expectations come from
// AXI burst rules (one B per AW, arlen+1 beats, RLAST on the final beat).
module tb_taxi_axi_err_slv;
    import taxi_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned aw_hs_cyc = 0;
    int unsigned ar_hs_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    taxi_axi_if #(.DATA_W(32), .ID_W(8)) axi ();
    taxi_axi_if #(.DATA_W(32), .ID_W(8)) axi2 ();

    taxi_axi_err_slv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_axi_wr (axi),
        .s_axi_rd (axi)
    );

    taxi_axi_err_slv #(.RESP(RESP_SLVERR)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_axi_wr (axi2),
        .s_axi_rd (axi2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic init_inputs();
        axi.awid = '0;  axi.awaddr = '0; axi.awlen = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '1;  axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b0;
        axi.arid = '0;  axi.araddr = '0; axi.arlen = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;
        axi2.awid = '0; axi2.awaddr = '0; axi2.awlen = '0; axi2.awvalid = 1'b0;
        axi2.wdata = '0; axi2.wstrb = '1; axi2.wlast = 1'b0; axi2.wvalid = 1'b0;
        axi2.bready = 1'b0;
        axi2.arid = '0; axi2.araddr = '0; axi2.arlen = '0; axi2.arvalid = 1'b0;
        axi2.rready = 1'b0;
    endtask

    // Write transaction on the default instance; called at a negedge.
    task automatic wr_burst(input logic [7:0] id, input int nbeats, input bit gaps, input int bhold);
        int n;
        int beat;
        axi.awid = id; axi.awlen = 8'(nbeats - 1); axi.awaddr = $urandom; axi.awvalid = 1'b1;
        n = 0;
        while (!axi.awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_accept_in_time", (n < 50), 1'b1);
        aw_hs_cyc = cyc;
        @(negedge clk);
        axi.awvalid = 1'b0;
        chk("wready_after_aw", axi.wready, 1'b1);
        beat = 0; n = 0;
        while (beat < nbeats && n < 1000) begin
            chk("no_b_before_wlast", axi.bvalid, 1'b0);
            axi.wvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.wlast  = (beat == nbeats - 1);
            axi.wdata  = $urandom;
            if (axi.wvalid && axi.wready) beat++;
            @(negedge clk); n++;
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        chk("w_beats_taken", beat, nbeats);
        chk("bvalid_after_wlast", axi.bvalid, 1'b1);
        chk("wready_low_in_resp", axi.wready, 1'b0);
        chk("bid", axi.bid, id);
        chk("bresp", axi.bresp, RESP_DECERR);
        chk("buser", axi.buser, 1'b0);
        for (int i = 0; i < bhold; i++) begin
            @(negedge clk);
            chk("b_hold_valid", axi.bvalid, 1'b1);
            chk("b_hold_bid", axi.bid, id);
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        chk("bvalid_clear_after_b", axi.bvalid, 1'b0);
        chk("awready_after_b", axi.awready, 1'b1);
    endtask

    // Read transaction on the default instance; called at a negedge.
    task automatic rd_burst(input logic [7:0] id, input int len, input bit rand_rdy);
        int   n;
        int   beat;
        bit   stalled;
        logic [7:0] s_rid;
        logic s_rlast;
        axi.arid = id; axi.arlen = 8'(len); axi.araddr = $urandom; axi.arvalid = 1'b1;
        n = 0;
        while (!axi.arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_accept_in_time", (n < 50), 1'b1);
        ar_hs_cyc = cyc;
        @(negedge clk);
        axi.arvalid = 1'b0;
        chk("rvalid_after_ar", axi.rvalid, 1'b1);
        chk("arready_low_in_data", axi.arready, 1'b0);
        beat = 0; n = 0; stalled = 1'b0; s_rid = '0; s_rlast = 1'b0;
        while (beat <= len && n < 5000) begin
            if (stalled) begin
                chk("r_stall_valid", axi.rvalid, 1'b1);
                chk("r_stall_rid", axi.rid, s_rid);
                chk("r_stall_rlast", axi.rlast, s_rlast);
            end
            axi.rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi.rvalid) begin
                chk("rid", axi.rid, id);
                chk("rresp", axi.rresp, RESP_DECERR);
                chk("rdata", axi.rdata, 32'h0);
                chk("rlast_pos", axi.rlast, (beat == len));
                if (axi.rready) begin
                    beat++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; s_rid = axi.rid; s_rlast = axi.rlast;
                end
            end
            @(negedge clk); n++;
        end
        axi.rready = 1'b0;
        chk("r_beat_count", beat, len + 1);
        chk("rvalid_done", axi.rvalid, 1'b0);
        chk("rlast_done", axi.rlast, 1'b0);
        chk("arready_after_r", axi.arready, 1'b1);
    endtask

    initial begin
        init_inputs();
        repeat (2) @(negedge clk);
        chk("rst_awready", axi.awready, 1'b0);
        chk("rst_wready",  axi.wready,  1'b0);
        chk("rst_bvalid",  axi.bvalid,  1'b0);
        chk("rst_arready", axi.arready, 1'b0);
        chk("rst_rvalid",  axi.rvalid,  1'b0);
        chk("rst_rlast",   axi.rlast,   1'b0);
        chk("rst_bid",     axi.bid,     8'h0);
        chk("rst_rid",     axi.rid,     8'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", axi.awready, 1'b1);
        chk("post_rst_arready", axi.arready, 1'b1);

        // single write, then 8-beat read
        wr_burst(8'd5, 1, 1'b0, 0);
        rd_burst(8'd3, 7, 1'b0);

        // backpressure on both paths at once
        fork
            rd_burst(8'h11, 255, 1'b1);
            wr_burst(8'h22, 16, 1'b1, 10);
        join

        // concurrency: AW and AR presented together
        @(negedge clk);
        fork
            wr_burst(8'd1, 4, 1'b0, 2);
            rd_burst(8'd2, 3, 1'b0);
        join
        chk("aw_ar_same_cycle", ar_hs_cyc, aw_hs_cyc);

        // reset in the middle of a read burst and a write burst
        @(negedge clk);
        axi.awid = 8'd4; axi.awlen = 8'd7; axi.awvalid = 1'b1;
        axi.arid = 8'd6; axi.arlen = 8'd7; axi.arvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.arvalid = 1'b0;
        axi.wvalid = 1'b1; axi.wlast = 1'b0; axi.rready = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rvalid", axi.rvalid, 1'b1);
        chk("mid_wready", axi.wready, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rvalid",  axi.rvalid,  1'b0);
        chk("async_rlast",   axi.rlast,   1'b0);
        chk("async_bvalid",  axi.bvalid,  1'b0);
        chk("async_awready", axi.awready, 1'b0);
        chk("async_wready",  axi.wready,  1'b0);
        chk("async_arready", axi.arready, 1'b0);
        axi.wvalid = 1'b0; axi.rready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready", axi.awready, 1'b1);
        chk("rel_arready", axi.arready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_b_after_rst", axi.bvalid, 1'b0);
            chk("no_r_after_rst", axi.rvalid, 1'b0);
        end
        rd_burst(8'd7, 0, 1'b0);

        // RESP override instance
        @(negedge clk);
        axi2.awid = 8'd9; axi2.awvalid = 1'b1;
        chk("p2_awready", axi2.awready, 1'b1);
        @(negedge clk);
        axi2.awvalid = 1'b0; axi2.wvalid = 1'b1; axi2.wlast = 1'b1;
        chk("p2_wready", axi2.wready, 1'b1);
        @(negedge clk);
        axi2.wvalid = 1'b0; axi2.wlast = 1'b0;
        chk("p2_bvalid", axi2.bvalid, 1'b1);
        chk("p2_bresp", axi2.bresp, RESP_SLVERR);
        chk("p2_bid", axi2.bid, 8'd9);
        axi2.bready = 1'b1;
        @(negedge clk);
        axi2.bready = 1'b0;
        axi2.arid = 8'd12; axi2.arlen = 8'd0; axi2.arvalid = 1'b1;
        chk("p2_bvalid_clear", axi2.bvalid, 1'b0);
        chk("p2_arready", axi2.arready, 1'b1);
        @(negedge clk);
        axi2.arvalid = 1'b0;
        chk("p2_rvalid", axi2.rvalid, 1'b1);
        chk("p2_rresp", axi2.rresp, RESP_SLVERR);
        chk("p2_rlast", axi2.rlast, 1'b1);
        chk("p2_rid", axi2.rid, 8'd12);
        axi2.rready = 1'b1;
        @(negedge clk);
        axi2.rready = 1'b0;
        chk("p2_rvalid_clear", axi2.rvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/taxi_axi_err_slv.md
Name: taxi_axi_err_slv

Overview:
- AXI4 default/terminating slave for unused or unmapped master ports of the single-slave interconnect, sitting directly downstream of one of its m_axi_wr/m_axi_rd ports.
- Accepts any legal burst, drains write data, and returns a fixed error response (DECERR by default).
- Full AXI4 burst compliance: exactly one B per AW, exactly arlen+1 R beats with RLAST per AR, IDs echoed.
- One outstanding transaction per direction; read and write paths are fully independent.

Parameters:
- RESP, 2'b11, response code driven on bresp/rresp (2'b10 = SLVERR, 2'b11 = DECERR).
- RDATA_VAL, '0, constant driven on rdata, zero-extended or truncated to the interface DATA_W.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_axi_wr  taxi_axi_if.wr_slv  interface  write slave. Uses awid, awvalid, awready, wvalid, wready, wlast, bid, bresp, bvalid, bready, buser. Data/addr/strb/len ignored.
- s_axi_rd  taxi_axi_if.rd_slv  interface  read slave. Uses arid, arlen, arvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid, rready.

Behaviour:
- Reset: rst_n low asserts immediately, asynchronously, and forces:
  - awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bid=0, rid=0.
  - Both FSMs go to IDLE.
- First cycle after rst_n deasserts: awready=1 and arready=1.
- Reset mid-burst abandons the burst; no B or R is emitted afterwards.
- buser=0, ruser=0, bresp=RESP, rresp=RESP, rdata=RDATA_VAL at all times. All control outputs are registered.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1, wready=0. On awvalid&&awready: capture awid into bid, go to W_DATA; awready=0 from the next cycle.
  - W_DATA: wready=1. Each wvalid beat is consumed. On wvalid&&wlast: wready=0 and bvalid=1 from the next cycle, go to W_RESP.
  - W_DATA ignores awlen: it drains until WLAST. A burst with a 1-beat WLAST yields a B after 1 beat.
  - W_RESP: bvalid held with a stable bid until bready. On bvalid&&bready: bvalid=0, awready=1 next cycle, go to W_IDLE.
  - W beats presented before AW are not accepted (wready=0 in W_IDLE). This is legal slave behaviour.
- Write latency: AW handshake at cycle N gives first possible W accept at N+1. WLAST at cycle M gives bvalid at M+1. B handshake at K gives awready at K+1. Minimum single-beat write transaction: 4 cycles.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1, rvalid=0. On arvalid&&arready: capture arid into rid, load 8-bit beat counter with arlen, set rvalid=1 next cycle, set rlast=(arlen==0), go to R_DATA.
  - R_DATA: rvalid=1. On rvalid&&rready with counter!=0: decrement the counter; rlast=1 when the counter becomes 0.
  - R_DATA, on rvalid&&rready&&rlast: rvalid=0, rlast=0, arready=1 next cycle, go to R_IDLE.
  - rid, rlast and rdata stay stable while rvalid&&!rready (backpressure).
- Beat count: arlen=255 gives exactly 256 beats. The counter never underflows or wraps.
- Read and write FSMs run concurrently. Simultaneous AW and AR handshakes in the same cycle are both accepted.

Decomposition:
- Shared package taxi_axi_pkg holds the response-code constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11. RESP defaults to RESP_DECERR.
- FSM state enums stay local to each half.
- Split into mirrored halves taxi_axi_err_slv_wr and taxi_axi_err_slv_rd, each with clk/rst_n and one interface modport. The top instantiates both and passes parameters through.

Test Plan:
- Single write: AW id=5 len=0, one W with wlast -> exactly one B with bid=5, bresp=2'b11, bvalid 1 cycle after WLAST; awready returns 1 cycle after B handshake.
- Burst read: AR id=3 len=7, rready=1 -> 8 R beats, rid=3, rresp=2'b11, rdata=0, rlast only on the 8th beat; arready high 1 cycle after the last beat.
- Backpressure: AR len=255 with random rready, plus a write whose 16 W beats carry random wvalid gaps and a bready held low 10 cycles -> exactly 256 R beats with stable outputs while stalled; B held stable until bready.
- Concurrency: AW id=1 and AR id=2 issued in the same cycle -> both accepted that cycle; B id=1 and R id=2 complete independently.
- Reset mid-burst: drop rst_n during beat 3 of an 8-beat read and mid-W-burst -> rvalid, bvalid and all readies go 0 without waiting for a clock edge; after release, awready=arready=1 and the next AR len=0 returns one beat with rlast=1.
- Parameter override: RESP=2'b10 -> bresp and rresp both equal 2'b10 for a write and a read.
